// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if
//   Bundles the loader's byte-stream input handshake and the instruction-memory
//   write port.
//   Handshake: a byte transfers on every rising clk edge where rx_valid and
//   rx_ready are both 1. The source holds rx_data stable while rx_valid is high
//   and not yet accepted. rx_ready depends only on loader state, never on
//   rx_valid.
//   Signals:
//     rx_valid   - source has a byte on rx_data
//     rx_data    - byte-stream data
//     rx_ready   - loader can accept a byte this cycle
//     imem_we    - one-cycle write strobe per word
//     imem_addr  - word address (AW bits)
//     imem_wdata - 32-bit word
//   Modports: master = loader side, slave = stream source / memory side.
interface imem_boot_loader_if #(
  parameter int AW = 8
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a little-endian byte stream into instruction memory. The stream is
//   LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes. The first byte
//   of each word lands in bits [7:0]. The core is held in reset until the load
//   completes.
//   Optional feature (macro LOADER_CHECKSUM_EN): one trailing byte must equal
//   the XOR of all data bytes. A match ends in DONE; a mismatch ends in FAIL.
//   Ports:
//     clk, reset  - rising-edge clock; synchronous active-high reset
//     reload      - one-cycle pulse; restarts loading from any state
//     bus         - imem_boot_loader_if.master (rx handshake + imem write)
//     core_rst_n  - active-low core reset; high only after a good load
//     done, err   - load succeeded / failed (overflow or bad checksum)
//     dbg_state   - current FSM state, for observation
//   Parameters: DEPTH (words, at most 65536), AW (2**AW >= DEPTH, AW <= 16).
module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reload,
  imem_boot_loader_if.master  bus,
  output logic                core_rst_n,
  output logic                done,
  output logic                err,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_EXIT_OK = S_CHK;
`else
  localparam logic [2:0] S_EXIT_OK = S_DONE;
`endif

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   idx_q, idx_d;      // wide enough that it never wraps
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   asm_q, asm_d;      // first three bytes of the current word
  logic          ovf_q, ovf_d;
  logic [7:0]    chk_q, chk_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          ovf_now;
  logic [15:0]   len_full;

  assign bus.rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHK);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign len_full     = {bus.rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    chk_d   = chk_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_now = ovf_q;

    if (reload) begin
      // reload beats any byte being accepted on the same edge
      state_d = S_IDLE;
      len_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      chk_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_LEN_LO;
        S_LEN_LO: begin
          if (accept) begin
            len_d[7:0] = bus.rx_data;
            state_d    = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_d   = len_full;
            state_d = (len_full == 16'd0) ? S_EXIT_OK : S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            chk_d = chk_q ^ bus.rx_data;
            cnt_d = cnt_q + 2'd1;
            asm_d = {bus.rx_data, asm_q[23:8]};
            if (cnt_q == 2'd3) begin
              idx_d = idx_q + 16'd1;
              if ({1'b0, idx_q} < DEPTH_L) begin
                we_d    = 1'b1;
                addr_d  = idx_q[AW-1:0];
                wdata_d = {bus.rx_data, asm_q};
              end else begin
                // out-of-range words are swallowed; address never wraps
                ovf_now = 1'b1;
              end
              ovf_d = ovf_now;
              if (idx_q + 16'd1 == len_q) begin
                state_d = ovf_now ? S_FAIL : S_EXIT_OK;
              end
            end
          end
        end
        S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) begin
            state_d = (bus.rx_data == chk_q) ? S_DONE : S_FAIL;
          end
`else
          state_d = S_FAIL;
`endif
        end
        S_DONE, S_FAIL: state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end

    // Status is registered from the current state, so done rises one cycle
    // after the final word's write strobe. reload clears it on the same edge.
    done_d = (state_q == S_DONE) && !reload;
    err_d  = (state_q == S_FAIL) && !reload;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      chk_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      chk_q   <= chk_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign done           = done_q;
  assign err            = err_q;
  assign core_rst_n     = done_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction-memory depth in 32-bit words.
REQ-002 Parameter: AW, 8, word-address width; the SHALL satisfy 2**AW >= DEPTH.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reload  input  1  single-cycle pulse that SHALL restart loading from any state.
REQ-006 rx_valid  input  1  byte-stream valid.
REQ-007 rx_data  input  8  byte-stream data.
REQ-008 rx_ready  output  1  loader accepts a byte when rx_valid && rx_ready.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  AW  word address of the write.
REQ-011 imem_wdata  output  32  word to write.
REQ-012 core_rst_n  output  1  active-low reset for the single-cycle core; low until load completes.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load failed: overflow, or checksum mismatch when enabled.

Function
REQ-015 Stream format SHALL be LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes; each word is little-endian, so the first byte goes to [7:0].
REQ-016 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, FAIL.
REQ-017 IDLE SHALL go to LEN_LO on the cycle after reset or reload.
REQ-018 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CHK, and 0 in IDLE, DONE and FAIL.
REQ-019 After LEN_HI is accepted, N=0 SHALL go to CHK when checksum is enabled, otherwise to DONE.
REQ-020 A 2-bit byte counter SHALL shift bytes into the assembly register; the 4th accepted byte SHALL cause imem_we=1 on the next cycle with the assembled word and the current word index.
REQ-021 The word index SHALL start at 0 and increment after each write; the DATA exit SHALL occur when index+1 == N on the 4th byte.
REQ-022 Words with index >= DEPTH SHALL be consumed but not written, imem_we=0, and a sticky overflow flag SHALL be set; the index SHALL not wrap into imem_addr.
REQ-023 DATA exit SHALL go to FAIL if overflow is set, else to CHK or DONE per configuration.
REQ-024 Gaps in rx_valid SHALL stall the FSM without losing state; there is no timeout.
REQ-025 In DONE: done=1, core_rst_n=1, err=0.
REQ-026 In FAIL: err=1, done=0, core_rst_n=0.
REQ-027 In all other states: done=0, err=0, core_rst_n=0.
REQ-028 reload SHALL win over a simultaneous byte acceptance: the byte is dropped, the FSM goes to IDLE, core_rst_n drops the same edge, and the counters and overflow flag clear.
REQ-029 imem_we SHALL never assert outside DATA-derived writes; the last word's write SHALL complete before done rises (done at least 1 cycle after the final imem_we).

Reset
REQ-030 On reset: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, done=0, err=0, counters, length, checksum and overflow cleared.
REQ-031 reset asserted mid-load SHALL abandon the load with no further imem_we.
REQ-032 reset SHALL have priority over reload.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: one trailing byte is accepted in CHK; it SHALL equal the XOR of all 4*N data bytes; a match goes to DONE, a mismatch goes to FAIL.
REQ-034 Macro LOADER_CHECKSUM_EN undefined: CHK is unreachable, no checksum byte is consumed, and the DATA/length exits go directly to DONE.

Verification
REQ-035 Load N=2 of words 0x00000013, 0x00A00093: bytes 02 00 13 00 00 00 93 00 A0 00 -> imem_we at addr 0 then 1 with those words, then done=1 and core_rst_n=1.
REQ-036 N=0 (bytes 00 00) -> no imem_we; done=1 (with checksum enabled, send byte 00 first).
REQ-037 DEPTH=4, N=5 -> 4 writes at addr 0..3, the fifth word is consumed without a write, then err=1, core_rst_n=0, rx_ready=0.
REQ-038 Checksum enabled, N=1 word 0x11223344, checksum 0x44 -> done=1; checksum 0x45 -> err=1.
REQ-039 reload asserted while the third data byte has rx_valid=1 -> the byte is dropped, core_rst_n=0 immediately, and a new full stream loads correctly from addr 0.
REQ-040 rx_valid toggled 1/0 on alternate cycles through a full N=3 load -> identical imem writes and final state as the back-to-back stream.
